// File: rtl/noise_generator.sv
// rtl/noise_generator.sv - divided-rate LFSR noise source with white/periodic feedback
module noise_generator #(
    parameter int                   LFSR_BITS = 15,
    parameter logic [LFSR_BITS-1:0] TAP_MASK  = 15'h0003,
    parameter int                   DIV_BITS  = 7
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       control_wr,
    input  logic [2:0] control,
    input  logic       tone3_edge,
    output logic       out,
    output logic       shift_strobe
);

    localparam logic [LFSR_BITS-1:0] SEED     = {1'b1, {(LFSR_BITS-1){1'b0}}};
    localparam logic [DIV_BITS-1:0]  TERM_32  = DIV_BITS'(31);
    localparam logic [DIV_BITS-1:0]  TERM_64  = DIV_BITS'(63);
    localparam logic [DIV_BITS-1:0]  TERM_128 = DIV_BITS'(127);

    if (TAP_MASK[0] != 1'b1) begin : g_bad_tap
        $error("noise_generator: TAP_MASK bit 0 must be set");
    end
    if (LFSR_BITS < 4 || LFSR_BITS > 24) begin : g_bad_width
        $error("noise_generator: LFSR_BITS must be within 4..24");
    end
    if (DIV_BITS < 7) begin : g_bad_div
        $error("noise_generator: DIV_BITS must be at least 7");
    end

    logic [2:0]           ctrl_q, ctrl_d;
    logic [DIV_BITS-1:0]  cnt_q, cnt_d;
    logic [LFSR_BITS-1:0] lfsr_q, lfsr_d;
    logic                 shift_strobe_q, shift_strobe_d;
    logic [DIV_BITS-1:0]  term;
    logic                 shift_fire;
    logic                 feedback;

    always_comb begin
        term = TERM_128;
        case (ctrl_q[1:0])
            2'b00:   term = TERM_32;
            2'b01:   term = TERM_64;
            default: term = TERM_128;
        endcase
    end

    // White mode feeds back tap parity; periodic mode recirculates bit 0.
    always_comb begin
        feedback = ctrl_q[2] ? ^(lfsr_q & TAP_MASK) : lfsr_q[0];
    end

    always_comb begin
        ctrl_d     = ctrl_q;
        cnt_d      = cnt_q;
        lfsr_d     = lfsr_q;
        shift_fire = 1'b0;
        if (control_wr) begin
            ctrl_d = control;
            cnt_d  = '0;
            lfsr_d = SEED;
        end else begin
            if (enable) begin
                if (ctrl_q[1:0] == 2'b11) begin
                    cnt_d      = '0;
                    shift_fire = tone3_edge;
                end else if (cnt_q == term) begin
                    cnt_d      = '0;
                    shift_fire = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            // An all-zero register would never leave zero, so it is reseeded.
            if (lfsr_q == '0) begin
                lfsr_d = SEED;
            end else if (shift_fire) begin
                lfsr_d = {feedback, lfsr_q[LFSR_BITS-1:1]};
            end
        end
        shift_strobe_d = shift_fire;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q         <= 3'b000;
            cnt_q          <= '0;
            lfsr_q         <= SEED;
            shift_strobe_q <= 1'b0;
        end else begin
            ctrl_q         <= ctrl_d;
            cnt_q          <= cnt_d;
            lfsr_q         <= lfsr_d;
            shift_strobe_q <= shift_strobe_d;
        end
    end

    assign out          = lfsr_q[0];
    assign shift_strobe = shift_strobe_q;

endmodule

// File: tb/tb_noise_generator.sv
// tb/tb_noise_generator.sv - scoreboard bench for noise_generator (default and 16-bit builds)
module tb_noise_generator;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable;
    logic       control_wr;
    logic [2:0] control;
    logic       tone3_edge;
    logic       out_a, strobe_a, out_b, strobe_b;

    int n_checks = 0;
    int n_errors = 0;
    int a_shifts = 0;
    int b_shifts = 0;
    bit zero_seen = 1'b0;

    logic [23:0] m_lfsr [2];
    logic [6:0]  m_cnt  [2];
    logic [2:0]  m_ctrl [2];
    int          m_w    [2] = '{15, 16};
    logic [23:0] m_tap  [2] = '{24'h0003, 24'h0009};
    logic [23:0] exp_q0 [$];
    logic [23:0] exp_q1 [$];

    always #5 clk = ~clk;

    noise_generator dut_a (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .control_wr   (control_wr),
        .control      (control),
        .tone3_edge   (tone3_edge),
        .out          (out_a),
        .shift_strobe (strobe_a)
    );

    noise_generator #(
        .LFSR_BITS (16),
        .TAP_MASK  (16'h0009),
        .DIV_BITS  (7)
    ) dut_b (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .control_wr   (control_wr),
        .control      (control),
        .tone3_edge   (tone3_edge),
        .out          (out_b),
        .shift_strobe (strobe_b)
    );

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [23:0] seed_of(input int idx);
        return 24'h1 << (m_w[idx] - 1);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_ctrl[i] = 3'b000;
            m_cnt[i]  = 7'd0;
            m_lfsr[i] = seed_of(i);
        end
        exp_q0.delete();
        exp_q1.delete();
    endtask

    task automatic model_step(input int idx, input logic en, input logic wr,
                              input logic [2:0] ctl, input logic t3);
        logic       fire;
        logic       nb;
        logic [6:0] term;
        fire = 1'b0;
        if (wr) begin
            m_ctrl[idx] = ctl;
            m_cnt[idx]  = 7'd0;
            m_lfsr[idx] = seed_of(idx);
        end else begin
            if (en) begin
                if (m_ctrl[idx][1:0] == 2'b11) begin
                    m_cnt[idx] = 7'd0;
                    fire = t3;
                end else begin
                    term = (m_ctrl[idx][1:0] == 2'b00) ? 7'd31 :
                           (m_ctrl[idx][1:0] == 2'b01) ? 7'd63 : 7'd127;
                    if (m_cnt[idx] == term) begin
                        m_cnt[idx] = 7'd0;
                        fire = 1'b1;
                    end else begin
                        m_cnt[idx] = m_cnt[idx] + 7'd1;
                    end
                end
            end
            if (m_lfsr[idx] == 24'd0) begin
                m_lfsr[idx] = seed_of(idx);
            end else if (fire) begin
                nb = m_ctrl[idx][2] ? ^(m_lfsr[idx] & m_tap[idx]) : m_lfsr[idx][0];
                m_lfsr[idx] = (m_lfsr[idx] >> 1) | ({23'd0, nb} << (m_w[idx] - 1));
            end
            if (fire) begin
                if (idx == 0) exp_q0.push_back(m_lfsr[idx]);
                else          exp_q1.push_back(m_lfsr[idx]);
            end
        end
    endtask

    task automatic cycle(input logic en, input logic wr, input logic [2:0] ctl, input logic t3);
        enable     = en;
        control_wr = wr;
        control    = ctl;
        tone3_edge = t3;
        model_step(0, en, wr, ctl, t3);
        model_step(1, en, wr, ctl, t3);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every strobe must match a shift the model predicted.
    always @(negedge clk) begin
        if (reset_n) begin
            if (dut_b.lfsr_q == 16'd0) zero_seen = 1'b1;
            if (strobe_a) begin
                a_shifts++;
                if (exp_q0.size() == 0) check_value("a_spurious_shift", 1, 0);
                else begin
                    logic [23:0] e;
                    e = exp_q0.pop_front();
                    check_value("a_lfsr", {17'd0, dut_a.lfsr_q}, e[15:0]);
                    check_value("a_out", {31'd0, out_a}, {31'd0, e[0]});
                end
            end
            if (strobe_b) begin
                b_shifts++;
                if (exp_q1.size() == 0) check_value("b_spurious_shift", 1, 0);
                else begin
                    logic [23:0] e;
                    e = exp_q1.pop_front();
                    check_value("b_lfsr", {16'd0, dut_b.lfsr_q}, e[15:0]);
                    check_value("b_out", {31'd0, out_b}, {31'd0, e[0]});
                end
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int sa, sb, dp, mp;
        reset_n = 1'b0; enable = 1'b0; control_wr = 1'b0; control = 3'b000; tone3_edge = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        check_value("rst_lfsr_a", dut_a.lfsr_q, 32'h4000);
        check_value("rst_lfsr_b", dut_b.lfsr_q, 32'h8000);
        check_value("rst_cnt", dut_a.cnt_q, 0);
        check_value("rst_ctrl", dut_a.ctrl_q, 0);
        check_value("rst_out", out_a, 0);
        check_value("rst_strobe", strobe_a, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // First shift after reset on the 32nd enable (NF=00, periodic).
        repeat (31) cycle(1, 0, 3'b000, 0);
        check_value("post_rst_cnt31", dut_a.cnt_q, 31);
        check_value("post_rst_noshift", a_shifts, 0);
        cycle(1, 0, 3'b000, 0);
        check_value("post_rst_shift", dut_a.lfsr_q, 32'h2000);
        check_value("strobe_high", strobe_a, 1);
        cycle(0, 0, 3'b000, 0);
        check_value("strobe_low", strobe_a, 0);

        // White mode, default taps.
        cycle(0, 1, 3'b100, 0);
        check_value("white_seed", dut_a.lfsr_q, 32'h4000);
        for (int s = 1; s <= 14; s++) begin
            repeat (32) cycle(1, 0, 3'b000, 0);
            if (s == 1)  check_value("white_s1", dut_a.lfsr_q, 32'h2000);
            if (s == 13) check_value("white_s13", dut_a.lfsr_q, 32'h0002);
            if (s == 14) begin
                check_value("white_s14", dut_a.lfsr_q, 32'h4001);
                check_value("white_s14_out", out_a, 1);
            end
        end

        // Periodic rotate.
        cycle(0, 1, 3'b000, 0);
        for (int s = 1; s <= 15; s++) begin
            repeat (32) cycle(1, 0, 3'b000, 0);
            check_value("periodic_out", out_a, (s == 14) ? 1 : 0);
        end
        check_value("periodic_wrap", dut_a.lfsr_q, 32'h4000);

        // Tone-3 driven shifts.
        cycle(0, 1, 3'b011, 0);
        sa = a_shifts;
        for (int k = 0; k < 3; k++) begin
            cycle(1, 0, 3'b000, 1);
            repeat (3) cycle(1, 0, 3'b000, 0);
        end
        check_value("tone3_shifts", a_shifts - sa, 3);
        check_value("tone3_cnt", dut_a.cnt_q, 0);
        sa = a_shifts;
        cycle(0, 0, 3'b000, 1);
        repeat (2) cycle(0, 0, 3'b000, 0);
        check_value("tone3_no_en", a_shifts - sa, 0);

        // Divide-by-128, rewrite mid-count, write coincident with terminal count.
        cycle(0, 1, 3'b110, 0);
        repeat (100) cycle(1, 0, 3'b000, 0);
        check_value("div128_cnt", dut_a.cnt_q, 100);
        cycle(0, 1, 3'b100, 0);
        check_value("rewrite_lfsr", dut_a.lfsr_q, 32'h4000);
        check_value("rewrite_cnt", dut_a.cnt_q, 0);
        sa = a_shifts;
        repeat (31) cycle(1, 0, 3'b000, 0);
        cycle(0, 0, 3'b000, 0);
        check_value("rewrite_31", a_shifts - sa, 0);
        cycle(1, 0, 3'b000, 0);
        cycle(0, 0, 3'b000, 0);
        check_value("rewrite_32", a_shifts - sa, 1);
        cycle(0, 1, 3'b110, 0);
        repeat (127) cycle(1, 0, 3'b000, 0);
        check_value("at_term", dut_a.cnt_q, 127);
        sa = a_shifts;
        cycle(1, 1, 3'b110, 0);
        cycle(0, 0, 3'b000, 0);
        check_value("wr_at_term_noshift", a_shifts - sa, 0);
        check_value("wr_at_term_cnt", dut_a.cnt_q, 0);
        repeat (5) cycle(1, 0, 3'b000, 0);
        cycle(0, 1, 3'b110, 0);
        check_value("same_wr_cnt", dut_a.cnt_q, 0);
        check_value("same_wr_lfsr", dut_a.lfsr_q, 32'h4000);

        // Asynchronous reset between edges, mid-count.
        cycle(0, 1, 3'b000, 0);
        repeat (10) cycle(1, 0, 3'b000, 0);
        cycle(1, 0, 3'b000, 0);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_value("async_cnt", dut_a.cnt_q, 0);
        check_value("async_lfsr_a", dut_a.lfsr_q, 32'h4000);
        check_value("async_lfsr_b", dut_b.lfsr_q, 32'h8000);
        check_value("async_out", out_a, 0);
        check_value("async_strobe", strobe_a, 0);
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        sa = a_shifts;
        repeat (31) cycle(1, 0, 3'b000, 0);
        check_value("async_rel_31", a_shifts - sa, 0);
        cycle(1, 0, 3'b000, 0);
        check_value("async_rel_32", dut_a.lfsr_q, 32'h2000);

        // Random-control soak.
        for (int i = 0; i < 2000; i++)
            cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 99) == 0),
                  3'($urandom), 1'($urandom_range(0, 1)));

        // White-mode period of the 16-bit build against the model.
        cycle(0, 1, 3'b111, 0);
        dp = 0; mp = 0;
        sb = b_shifts;
        for (int i = 1; i <= 65535; i++) begin
            cycle(1, 0, 3'b000, 1);
            if (dp == 0 && dut_b.lfsr_q == 16'h8000) dp = i;
            if (mp == 0 && m_lfsr[1] == 24'h008000) mp = i;
            if (dp != 0 && mp != 0) break;
        end
        cycle(0, 0, 3'b000, 0);
        check_value("period_found", (dp != 0), 1);
        check_value("period", dp, mp);
        check_value("period_strobes", b_shifts - sb, mp);
        check_value("never_zero", zero_seen, 0);
        check_value("queue_a_empty", exp_q0.size(), 0);
        check_value("queue_b_empty", exp_q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
